// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the 2-read/1-write register file.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int unsigned DEF_WORD_SIZE  = 8;
  localparam int unsigned DEF_NUM_REG    = 16;
  localparam int unsigned DEF_INDEX_SIZE = 4;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear-sweep sequencer: walks an index over 0..NUM_REG-1, one register per clock.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REG    = DEF_NUM_REG,
  parameter int unsigned INDEX_SIZE = DEF_INDEX_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clrReq,
  output logic                  clrBusy,
  output logic                  clrEn,
  output logic [INDEX_SIZE-1:0] clrIdx
);

  localparam logic [INDEX_SIZE-1:0] LAST_IDX = INDEX_SIZE'(NUM_REG - 1);

  state_t                  state_q, state_d;
  logic [INDEX_SIZE-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clrReq) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Stop at the last real register so non-power-of-two sizes never wrap.
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + INDEX_SIZE'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clrBusy = (state_q == ST_CLEAR);
  assign clrEn   = (state_q == ST_CLEAR);
  assign clrIdx  = cnt_q;

endmodule

// File: rtl/register_file_2r1w.sv
// NUM_REG x WORD_SIZE register file, two combinational read ports, one write port,
// valid bits and a clear sweep. Define REGFILE_BYPASS_EN for write-through forwarding.
module register_file_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
  parameter int unsigned NUM_REG    = DEF_NUM_REG,
  parameter int unsigned INDEX_SIZE = DEF_INDEX_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  loadReg,
  input  logic [INDEX_SIZE-1:0] wrAdd,
  input  logic [WORD_SIZE-1:0]  data_in,
  input  logic [INDEX_SIZE-1:0] rdAddA,
  input  logic [INDEX_SIZE-1:0] rdAddB,
  output logic [WORD_SIZE-1:0]  data_outA,
  output logic [WORD_SIZE-1:0]  data_outB,
  input  logic                  clrReq,
  output logic                  clrBusy,
  output logic                  wrDrop,
  output logic [NUM_REG-1:0]    regValid
);

  localparam logic [INDEX_SIZE:0] NUM_REG_W = (INDEX_SIZE + 1)'(NUM_REG);

  logic [WORD_SIZE-1:0]  regs_q [NUM_REG];
  logic [WORD_SIZE-1:0]  regs_d [NUM_REG];
  logic [NUM_REG-1:0]    valid_q, valid_d;
  logic                  wr_drop_q, wr_drop_d;
  logic                  clr_en;
  logic [INDEX_SIZE-1:0] clr_idx;
  logic                  addr_ok;
  logic                  wr_ok;

  regfile_clear_seq #(
    .NUM_REG    (NUM_REG),
    .INDEX_SIZE (INDEX_SIZE)
  ) u_clear_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clrReq  (clrReq),
    .clrBusy (clrBusy),
    .clrEn   (clr_en),
    .clrIdx  (clr_idx)
  );

  assign addr_ok = ({1'b0, wrAdd} < NUM_REG_W);
  assign wr_ok   = loadReg && !clrBusy && addr_ok;

  // Writes only happen outside a sweep, so the write and clear paths never hit the same edge.
  always_comb begin
    regs_d    = regs_q;
    valid_d   = valid_q;
    wr_drop_d = loadReg && !wr_ok;
    for (int unsigned i = 0; i < NUM_REG; i++) begin
      if (wr_ok && (wrAdd == INDEX_SIZE'(i))) begin
        regs_d[i]  = data_in;
        valid_d[i] = 1'b1;
      end
      if (clr_en && (clr_idx == INDEX_SIZE'(i))) begin
        regs_d[i]  = '0;
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REG; i++) begin
        regs_q[i] <= '0;
      end
      valid_q   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      valid_q   <= valid_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Out-of-range read addresses match no entry and fall through to zero.
  always_comb begin
    data_outA = '0;
    data_outB = '0;
    for (int unsigned i = 0; i < NUM_REG; i++) begin
      if (rdAddA == INDEX_SIZE'(i)) data_outA = regs_q[i];
      if (rdAddB == INDEX_SIZE'(i)) data_outB = regs_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (rdAddA == wrAdd)) data_outA = data_in;
    if (wr_ok && (rdAddB == wrAdd)) data_outB = data_in;
`endif
  end

  assign wrDrop   = wr_drop_q;
  assign regValid = valid_q;

endmodule
